// File: rtl/ex_muldiv_unit.sv
// EX-stage multi-cycle multiply/divide engine. It owns HI/LO, runs shift-add
// multiply and restoring divide at one bit per cycle, and asks the pipeline
// to hold while a result is pending.
module ex_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] PA,
  input  logic [WIDTH-1:0] PB,
  input  logic             hilo_read,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic             flush,
  output logic             stall_req,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q;
  logic              is_div_q, neg_lo_q, neg_hi_q, div_zero_q;
  // opb_q: multiplicand for multiply, divisor for divide
  logic [WIDTH-1:0]  opb_q;
  // acc_q/q_q: partial product/remainder and multiplier/quotient shift register
  logic [WIDTH-1:0]  acc_q, q_q, pa_q;
  logic [WIDTH-1:0]  acc_d, q_d;

  logic              accept, last;
  logic              pa_neg, pb_neg;
  logic [WIDTH-1:0]  abs_a, abs_b;
  logic [WIDTH:0]    mul_sum, shifted;
  logic [WIDTH+1:0]  diff;
  logic [2*WIDTH-1:0] prod, prod_res;
  logic [WIDTH-1:0]  quo, rem, hi_res, lo_res;

  assign busy        = (state_q == StBusy);
  assign done        = (state_q == StDone);
  assign div_by_zero = done & is_div_q & div_zero_q;
  assign stall_req   = busy & (start | hilo_read | hi_we | lo_we);

  // A new op is taken in IDLE or DONE unless it is being squashed.
  assign accept = (state_q != StBusy) & start & ~flush;
  assign last   = busy & ~flush & (cnt_q == CntW'(1));

  // Operand magnitudes; only the signed ops (op[0] == 0) look at the sign bits.
  always_comb begin
    pa_neg = ~op[0] & PA[WIDTH-1];
    pb_neg = ~op[0] & PB[WIDTH-1];
    abs_a  = pa_neg ? -PA : PA;
    abs_b  = pb_neg ? -PB : PB;
  end

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    mul_sum = {1'b0, acc_q} + (q_q[0] ? {1'b0, opb_q} : {(WIDTH + 1){1'b0}});
    shifted = {acc_q, q_q[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, opb_q};
    if (is_div_q) begin
      // Remainder always stays below 2^WIDTH, so the truncations are lossless.
      if (!diff[WIDTH+1]) begin
        acc_d = diff[WIDTH-1:0];
        q_d   = {q_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = shifted[WIDTH-1:0];
        q_d   = {q_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_d = mul_sum[WIDTH:1];
      q_d   = {mul_sum[0], q_q[WIDTH-1:1]};
    end
  end

  // Sign-corrected result from the final iteration.
  always_comb begin
    prod     = {acc_d, q_d};
    prod_res = neg_lo_q ? -prod : prod;
    quo      = neg_lo_q ? -q_d : q_d;
    rem      = neg_hi_q ? -acc_d : acc_d;
    hi_res   = prod_res[2*WIDTH-1:WIDTH];
    lo_res   = prod_res[WIDTH-1:0];
    if (is_div_q) begin
      if (div_zero_q) begin
        hi_res = pa_q;
        lo_res = {WIDTH{1'b1}};
      end else begin
        hi_res = rem;
        lo_res = quo;
      end
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: state_d = accept ? StBusy : StIdle;
      StBusy: begin
        if (flush)     state_d = StIdle;
        else if (last) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Operand latching and per-cycle iteration state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      div_zero_q <= 1'b0;
      opb_q      <= '0;
      acc_q      <= '0;
      q_q        <= '0;
      pa_q       <= '0;
    end else if (accept) begin
      cnt_q      <= CntW'(WIDTH);
      is_div_q   <= op[1];
      neg_lo_q   <= pa_neg ^ pb_neg;
      neg_hi_q   <= pa_neg;
      div_zero_q <= (PB == '0);
      opb_q      <= op[1] ? abs_b : abs_a;
      acc_q      <= '0;
      q_q        <= op[1] ? abs_a : abs_b;
      pa_q       <= PA;
    end else if (busy && !flush) begin
      cnt_q <= cnt_q - CntW'(1);
      acc_q <= acc_d;
      q_q   <= q_d;
    end
  end

  // HI/LO: result write on the last iteration, MTHI/MTLO when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      HI <= '0;
      LO <= '0;
    end else if (last) begin
      HI <= hi_res;
      LO <= lo_res;
    end else if (!busy && !accept) begin
      if (hi_we) HI <= PA;
      if (lo_we) LO <= PA;
    end
  end

endmodule
